// File: rtl/fsm_pkg.sv
// Shared types and defaults for the x/y input conditioner and the ones-counter FSM.
package fsm_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with stability counter,
// registered debounced level and a one-cycle press pulse.
module debounce_ch
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    logic             w_sync;
    db_state_t        w_state_next;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_sync = r_sync[1];

    // cnt holds the number of consecutive stable samples seen so far; it is
    // cleared on every settle, so it can never pass CNT_LAST.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            LOW: begin
                if (w_sync) begin
                    w_state_next = CHK_HIGH;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            CHK_HIGH: begin
                if (!w_sync) begin
                    w_state_next = LOW;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!w_sync) begin
                    w_state_next = CHK_LOW;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            CHK_LOW: begin
                if (w_sync) begin
                    w_state_next = HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= (w_state_next == HIGH) || (w_state_next == CHK_LOW);
            r_pulse <= (r_state == CHK_HIGH) && (w_state_next == HIGH);
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

// File: rtl/xy_input_conditioner.sv
// Two independent debounce channels producing the x/y step pulses and
// debounced levels for the downstream mod-4 ones-counter FSM.
module xy_input_conditioner
    import fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_x_raw,
    input  logic btn_y_raw,
    output logic x_pulse,
    output logic y_pulse,
    output logic x_level,
    output logic y_level
);

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_x (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_x_raw),
        .o_pulse (x_pulse),
        .o_level (x_level)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch_y (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_y_raw),
        .o_pulse (y_pulse),
        .o_level (y_level)
    );

endmodule

// File: tb/tb_xy_input_conditioner.sv
// Scenario bench for xy_input_conditioner with DEBOUNCE_CYCLES = 4; expected
// pulse edges are queued from the latency rule and matched as pulses appear.
module tb_xy_input_conditioner;

    localparam int D = 4;
    localparam int W = 16;

    logic clk;
    logic rst;
    logic btn_x_raw;
    logic btn_y_raw;
    logic x_pulse;
    logic y_pulse;
    logic x_level;
    logic y_level;

    int n_checks;
    int n_fail;
    int fsm_cnt;
    logic rnd_x [0:79];

    logic [W-1:0] x_exp_q[$];
    logic [W-1:0] y_exp_q[$];

    xy_input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_x_raw (btn_x_raw),
        .btn_y_raw (btn_y_raw),
        .x_pulse   (x_pulse),
        .y_pulse   (y_pulse),
        .x_level   (x_level),
        .y_level   (y_level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // raw inputs {y, x} driven before edge k of scenario sc
    function automatic logic [1:0] stim(input int sc, input int k);
        logic x;
        logic y;
        x = 1'b0;
        y = 1'b0;
        case (sc)
            0: x = (k >= 10) && (k < 60);
            1: y = (k >= 10) && (k <= 12);
            2: x = (k == 10) || (k == 12) || (k >= 14);
            3: begin x = (k >= 20); y = (k >= 20); end
            4: x = (k >= 10);
            5: x = ((k >= 10) && (k < 30)) || (k >= 40);
            6: x = rnd_x[k];
            default: ;
        endcase
        return {y, x};
    endfunction

    // edges from which a raw press is stable long enough to be accepted
    function automatic logic press_x(input int sc, input int k);
        return (sc == 0 && k == 10) || (sc == 2 && k == 14) || (sc == 3 && k == 20) ||
               (sc == 4 && k == 14) || (sc == 5 && (k == 10 || k == 40));
    endfunction

    function automatic logic press_y(input int sc, input int k);
        return (sc == 3 && k == 20);
    endfunction

    task automatic monitor(input int k);
        logic [W-1:0] e;
        fsm_cnt = (fsm_cnt + int'(x_pulse) + int'(y_pulse)) % 4;
        if (x_pulse) begin
            if (x_exp_q.size() == 0) begin
                check_eq("x_extra_pulse", {31'd0, x_pulse}, 32'd0);
            end else begin
                e = x_exp_q.pop_front();
                check_eq("x_pulse_edge", k, {16'd0, e});
            end
        end
        if (y_pulse) begin
            if (y_exp_q.size() == 0) begin
                check_eq("y_extra_pulse", {31'd0, y_pulse}, 32'd0);
            end else begin
                e = y_exp_q.pop_front();
                check_eq("y_pulse_edge", k, {16'd0, e});
            end
        end
    endtask

    task automatic level_checks(input int sc, input int k);
        case (sc)
            0: begin
                if (k == 14) check_eq("s0_xlvl_pre", {31'd0, x_level}, 0);
                if (k == 15) check_eq("s0_xlvl_on", {31'd0, x_level}, 1);
                if (k == 64) check_eq("s0_xlvl_hold", {31'd0, x_level}, 1);
                if (k == 65) check_eq("s0_xlvl_off", {31'd0, x_level}, 0);
                if (k == 15) check_eq("s0_ylvl", {31'd0, y_level}, 0);
            end
            1: check_eq("s1_ylvl_glitch", {31'd0, y_level}, 0);
            2: begin
                if (k == 18) check_eq("s2_xlvl_pre", {31'd0, x_level}, 0);
                if (k == 19) check_eq("s2_xlvl_on", {31'd0, x_level}, 1);
            end
            3: begin
                if (k == 24) check_eq("s3_lvls_pre", {30'd0, y_level, x_level}, 0);
                if (k == 25) check_eq("s3_lvls_on", {30'd0, y_level, x_level}, 3);
            end
            4: begin
                if (k == 13) check_eq("s4_outs_in_rst", {28'd0, y_level, y_pulse, x_level, x_pulse}, 0);
                if (k == 18) check_eq("s4_xlvl_pre", {31'd0, x_level}, 0);
                if (k == 19) check_eq("s4_xlvl_on", {31'd0, x_level}, 1);
            end
            5: begin
                if (k == 15) check_eq("s5_xlvl_on1", {31'd0, x_level}, 1);
                if (k == 34) check_eq("s5_xlvl_hold", {31'd0, x_level}, 1);
                if (k == 35) check_eq("s5_xlvl_off", {31'd0, x_level}, 0);
                if (k == 44) check_eq("s5_xlvl_pre2", {31'd0, x_level}, 0);
                if (k == 45) check_eq("s5_xlvl_on2", {31'd0, x_level}, 1);
            end
            6: check_eq("s6_xlvl_glitch", {31'd0, x_level}, 0);
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        btn_x_raw = 1'b0;
        btn_y_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("reset_outs", {28'd0, y_level, y_pulse, x_level, x_pulse}, 0);
        end
        rst     = 1'b0;
        fsm_cnt = 0;
    endtask

    // driver: edge k is the k-th rising edge after reset deassertion
    task automatic run_sc(input int sc, input int n);
        do_reset();
        for (int k = 0; k < n; k++) begin
            {btn_y_raw, btn_x_raw} = stim(sc, k);
            rst = (sc == 4) && (k == 13);
            if (press_x(sc, k)) x_exp_q.push_back(W'(k + 1 + D));
            if (press_y(sc, k)) y_exp_q.push_back(W'(k + 1 + D));
            @(posedge clk);
            #1;
            monitor(k);
            level_checks(sc, k);
        end
        rst = 1'b0;
        check_eq("x_missing_pulses", x_exp_q.size(), 0);
        check_eq("y_missing_pulses", y_exp_q.size(), 0);
        x_exp_q.delete();
        y_exp_q.delete();
    endtask

    initial begin
        int idx;
        int len;
        n_checks  = 0;
        n_fail    = 0;
        fsm_cnt   = 0;
        rst       = 1'b1;
        btn_x_raw = 1'b0;
        btn_y_raw = 1'b0;

        // random glitch train, every burst shorter than D samples
        idx = 0;
        for (int i = 0; i < 80; i++) rnd_x[i] = 1'b0;
        while (idx < 70) begin
            len = $urandom_range(1, D - 1);
            for (int j = 0; j < len && idx < 80; j++) begin
                rnd_x[idx] = 1'b1;
                idx++;
            end
            idx += $urandom_range(1, 5);
        end

        run_sc(0, 70);
        run_sc(1, 30);
        run_sc(2, 40);
        run_sc(3, 40);
        check_eq("s3_fsm_steps_to_s2", fsm_cnt, 2);
        run_sc(4, 30);
        run_sc(5, 60);
        run_sc(6, 80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
